// File: rtl/operand_fetch_unit.sv
// Operand fetch unit: loads one row of A or one column of B into the operand buffer
// over a single-outstanding req/gnt/rvalid memory port, stalling the controller meanwhile.
module operand_fetch_unit #(
    parameter int ROWS       = 8,
    parameter int K          = 9,
    parameter int COLS       = 10,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int A_BASE     = 0,
    parameter int B_BASE     = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fetch_row,
    input  logic                      fetch_col,
    input  logic [$clog2(ROWS)-1:0]   row_idx,
    input  logic [$clog2(COLS)-1:0]   col_idx,
    output logic                      mem_req,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [K*DATA_WIDTH-1:0]   mem_buffer,
    output logic                      mem_stall,
    output logic                      buf_valid,
    output logic                      err
);

    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_buf [K];
    logic                  r_err;

    logic                  w_any;
    logic                  w_row_ok;
    logic                  w_col_ok;
    logic                  w_legal;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_start;
    logic [ADDR_WIDTH-1:0] w_stride;

    assign w_any    = fetch_row | fetch_col;
    assign w_row_ok = 32'(row_idx) < ROWS;
    assign w_col_ok = 32'(col_idx) < COLS;
    assign w_legal  = (fetch_row ^ fetch_col) && (fetch_row ? w_row_ok : w_col_ok);
    assign w_last   = (r_cnt == LAST);

    // The only multiply: every later address is start + n*stride built incrementally.
    assign w_start  = fetch_row
                    ? ADDR_WIDTH'(A_BASE) + ADDR_WIDTH'(row_idx) * ADDR_WIDTH'(K)
                    : ADDR_WIDTH'(B_BASE) + ADDR_WIDTH'(col_idx);
    assign w_stride = fetch_row ? ADDR_WIDTH'(1) : ADDR_WIDTH'(COLS);

    assign mem_addr = r_addr;
    assign err      = r_err;

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        buf_valid = 1'b0;
        mem_stall = 1'b1;
        case (r_state)
            S_IDLE: begin
                mem_stall = w_legal;
                if (w_legal) w_next = S_REQ;
            end
            S_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) w_next = w_last ? S_DONE : S_REQ;
            end
            S_DONE: begin
                buf_valid = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_stride <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            for (int unsigned i = 0; i < K; i++) r_buf[i] <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= (r_state == S_IDLE) && w_any && !w_legal;
            if (r_state == S_IDLE && w_legal) begin
                r_addr   <= w_start;
                r_stride <= w_stride;
                r_cnt    <= '0;
            end
            if (r_state == S_WAIT && mem_rvalid) begin
                r_buf[r_cnt] <= mem_rdata;
                r_cnt        <= r_cnt + 1'b1;
                r_addr       <= r_addr + r_stride;
            end
        end
    end

    always_comb begin
        mem_buffer = '0;
        for (int unsigned i = 0; i < K; i++) mem_buffer[i*DATA_WIDTH +: DATA_WIDTH] = r_buf[i];
    end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Self-checking bench for operand_fetch_unit: table vectors, randomized handshake delays,
// reset abort, and a second instance with a high A_BASE to exercise address wrap.
module tb_operand_fetch_unit;

    localparam int ROWS = 8, K = 9, COLS = 10, DW = 16, AW = 16;
    localparam int A_BASE = 0, B_BASE = 256, WRAP_BASE = 16'hFFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            fetch_row, fetch_col;
    logic [2:0]      row_idx;
    logic [3:0]      col_idx;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_gnt, mem_rvalid;
    logic [DW-1:0]   mem_rdata;
    logic [K*DW-1:0] mem_buffer;
    logic            mem_stall, buf_valid, err;

    // memory responder (model) and manual override
    logic            m_gnt = 1'b0, m_rvalid = 1'b0;
    logic [DW-1:0]   m_rdata = '0;
    logic            manual = 1'b0, t_gnt = 1'b0, t_rvalid = 1'b0;
    logic [DW-1:0]   t_rdata = '0;
    assign mem_gnt    = manual ? t_gnt    : m_gnt;
    assign mem_rvalid = manual ? t_rvalid : m_rvalid;
    assign mem_rdata  = manual ? t_rdata  : m_rdata;

    operand_fetch_unit #(.ROWS(ROWS), .K(K), .COLS(COLS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                         .A_BASE(A_BASE), .B_BASE(B_BASE)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_row(fetch_row), .fetch_col(fetch_col),
        .row_idx(row_idx), .col_idx(col_idx), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_buffer(mem_buffer), .mem_stall(mem_stall), .buf_valid(buf_valid), .err(err)
    );

    // second instance with A placed near the top of the address space
    logic            w_fetch_row = 1'b0, w_fetch_col = 1'b0;
    logic [2:0]      w_row_idx = '0;
    logic [3:0]      w_col_idx = '0;
    logic            w_req, w_gnt = 1'b0, w_rvalid = 1'b0;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_rdata = '0;
    logic [K*DW-1:0] w_buffer;
    logic            w_stall, w_bvalid, w_err;

    operand_fetch_unit #(.ROWS(ROWS), .K(K), .COLS(COLS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                         .A_BASE(WRAP_BASE), .B_BASE(B_BASE)) u_wrap (
        .clk(clk), .rst_n(rst_n), .fetch_row(w_fetch_row), .fetch_col(w_fetch_col),
        .row_idx(w_row_idx), .col_idx(w_col_idx), .mem_req(w_req), .mem_addr(w_addr),
        .mem_gnt(w_gnt), .mem_rvalid(w_rvalid), .mem_rdata(w_rdata),
        .mem_buffer(w_buffer), .mem_stall(w_stall), .buf_valid(w_bvalid), .err(w_err)
    );

    int n_chk = 0, n_fail = 0;

    // responder state for the main instance
    bit            outstanding = 0, rnd_mode = 0;
    int            gnt_wait = 0, rv_wait = 0;
    logic          p_req = 1'b0;
    logic [AW-1:0] p_addr = '0, cur_addr = '0;
    logic [DW-1:0] salt = '0;
    logic [AW-1:0] obs_addr [1024];
    int            obs_n = 0, proto_err = 0;

    always @(negedge clk) begin
        if (!rst_n || manual) begin
            outstanding = 0; m_gnt = 1'b0; m_rvalid = 1'b0; p_req = 1'b0;
            gnt_wait = 0; rv_wait = 0;
        end else begin
            if (m_rvalid) outstanding = 0;
            if (m_gnt && p_req) begin
                outstanding = 1;
                cur_addr = p_addr;
                if (obs_n < 1024) obs_addr[obs_n] = p_addr;
                obs_n++;
                rv_wait  = rnd_mode ? int'($urandom_range(0, 5)) : 0;
                gnt_wait = rnd_mode ? int'($urandom_range(0, 5)) : 0;
            end
            if (mem_req && outstanding) proto_err++;
            if (p_req && !m_gnt && (!mem_req || mem_addr != p_addr)) proto_err++;
            m_gnt = 1'b0; m_rvalid = 1'b0;
            if (outstanding) begin
                if (rv_wait == 0) begin m_rvalid = 1'b1; m_rdata = cur_addr ^ salt; end
                else rv_wait--;
            end else if (mem_req) begin
                if (gnt_wait == 0) m_gnt = 1'b1;
                else gnt_wait--;
            end
            p_req = mem_req; p_addr = mem_addr;
        end
    end

    // fixed-latency responder for the wrap instance: data = address
    logic          wp_req = 1'b0;
    logic [AW-1:0] wp_addr = '0;
    logic [AW-1:0] wobs [64];
    int            wobs_n = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            w_gnt = 1'b0; w_rvalid = 1'b0; wp_req = 1'b0;
        end else begin
            w_rvalid = 1'b0;
            if (w_gnt && wp_req) begin
                if (wobs_n < 64) wobs[wobs_n] = wp_addr;
                wobs_n++;
                w_rvalid = 1'b1;
                w_rdata  = wp_addr;
            end
            w_gnt  = w_req && !w_rvalid;
            wp_req = w_req; wp_addr = w_addr;
        end
    end

    logic [DW-1:0] exp_buf [K];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] ref_addr(bit row, int idx, int i, int abase);
        int a;
        a = row ? abase + idx * K + i : B_BASE + idx + i * COLS;
        return AW'(a);
    endfunction

    function automatic bit ref_legal(bit row, bit col, int idx);
        if (row == col) return 0;
        return row ? (idx < ROWS) : (idx < COLS);
    endfunction

    task automatic chk_buffer(input string tag);
        for (int i = 0; i < K; i++)
            chk($sformatf("%s_buf[%0d]", tag, i), 32'(mem_buffer[i*DW +: DW]), 32'(exp_buf[i]));
    endtask

    task automatic run_req(input bit row, input bit col, input logic [3:0] idx, input bit rnd,
                           input bit timed, input logic [DW-1:0] sl, input bit exp_err,
                           input logic [AW-1:0] exp_first);
        int base, pe0, cyc;
        bit seen;
        rnd_mode = rnd;
        salt     = sl;
        @(negedge clk);
        base = obs_n; pe0 = proto_err;
        fetch_row = row; fetch_col = col; row_idx = idx[2:0]; col_idx = idx;
        #1 chk("stall_on_request", 32'(mem_stall), 32'(!exp_err));
        @(negedge clk);
        fetch_row = 1'b0; fetch_col = 1'b0;
        chk("err_pulse", 32'(err), 32'(exp_err));
        if (exp_err) begin
            chk("illegal_no_req", 32'(mem_req), 0);
            chk("illegal_no_stall", 32'(mem_stall), 0);
            chk_buffer("illegal");
            @(negedge clk);
            chk("err_one_cycle", 32'(err), 0);
            chk("illegal_no_grant", 32'(obs_n - base), 0);
            return;
        end
        cyc = 1; seen = 0;
        while (!seen && cyc < 400) begin
            if (buf_valid === 1'b1) seen = 1;
            else begin @(negedge clk); cyc++; end
        end
        chk("buf_valid_seen", 32'(seen), 1);
        if (!seen) return;
        if (timed) chk("buf_valid_cycle", 32'(cyc), 19);
        chk("read_count", 32'(obs_n - base), 32'(K));
        chk("first_addr", 32'(obs_addr[base]), 32'(exp_first));
        for (int i = 0; i < K; i++) begin
            exp_buf[i] = ref_addr(row, int'(idx), i, A_BASE) ^ sl;
            chk($sformatf("addr[%0d]", i), 32'(obs_addr[base+i]), 32'(ref_addr(row, int'(idx), i, A_BASE)));
        end
        chk_buffer("fetch");
        @(negedge clk);
        chk("buf_valid_pulse", 32'(buf_valid), 0);
        chk("stall_release", 32'(mem_stall), 0);
        chk("protocol", 32'(proto_err - pe0), 0);
    endtask

    typedef struct {
        bit            row;
        bit            col;
        logic [3:0]    idx;
        bit            rnd;
        bit            timed;
        logic [DW-1:0] sl;
        bit            exp_err;
        logic [AW-1:0] exp_first;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ridx, kind;
        bit rr, rc;
        logic [3:0] ri;
        logic [DW-1:0] rs;
        int wbase, cyc;
        bit seen;

        tbl[0] = '{1, 0, 4'd2,  0, 1, 16'h0000, 0, 16'd18};
        tbl[1] = '{0, 1, 4'd3,  0, 1, 16'h0000, 0, 16'd259};
        tbl[2] = '{1, 0, 4'd7,  1, 0, 16'h5A5A, 0, 16'd63};
        tbl[3] = '{0, 1, 4'd9,  1, 0, 16'h1234, 0, 16'd265};
        tbl[4] = '{1, 1, 4'd1,  0, 0, 16'h0000, 1, 16'd0};
        tbl[5] = '{0, 1, 4'd10, 0, 0, 16'h0000, 1, 16'd0};
        tbl[6] = '{0, 1, 4'd15, 0, 0, 16'h0000, 1, 16'd0};
        tbl[7] = '{0, 1, 4'd0,  1, 0, 16'h00FF, 0, 16'd256};

        rst_n = 1'b0; fetch_row = 1'b0; fetch_col = 1'b0; row_idx = '0; col_idx = '0;
        for (int i = 0; i < K; i++) exp_buf[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_buf_valid", 32'(buf_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_stall", 32'(mem_stall), 0);
        chk_buffer("rst");
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++)
            run_req(tbl[v].row, tbl[v].col, tbl[v].idx, tbl[v].rnd, tbl[v].timed,
                    tbl[v].sl, tbl[v].exp_err, tbl[v].exp_first);

        for (int n = 0; n < 12; n++) begin
            kind = int'($urandom_range(0, 9));
            rr = (kind < 5) || (kind == 9);
            rc = (kind >= 5);
            ri = rr && !rc ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
            rs = 16'($urandom);
            ridx = int'(ri);
            run_req(rr, rc, ri, 1, 0, rs, !ref_legal(rr, rc, ridx),
                    ref_legal(rr, rc, ridx) ? ref_addr(rr, ridx, 0, A_BASE) : '0);
        end

        // reset while waiting on the 4th word, then a stray rvalid
        manual = 1'b1;
        @(negedge clk);
        fetch_row = 1'b1; row_idx = 3'd3;
        @(negedge clk);
        fetch_row = 1'b0;
        for (int w = 0; w < 3; w++) begin
            chk("abort_addr", 32'(mem_addr), 32'(27 + w));
            t_gnt = 1'b1; @(negedge clk); t_gnt = 1'b0;
            t_rvalid = 1'b1; t_rdata = 16'hC000 + 16'(w); @(negedge clk); t_rvalid = 1'b0;
        end
        chk("abort_4th_req", 32'(mem_req), 1);
        t_gnt = 1'b1; @(negedge clk); t_gnt = 1'b0;
        chk("partial_word0", 32'(mem_buffer[0 +: DW]), 32'h0000C000);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; t_rvalid = 1'b1; t_rdata = 16'hBEEF;
        @(negedge clk);
        t_rvalid = 1'b0;
        for (int i = 0; i < K; i++) exp_buf[i] = '0;
        chk("abort_mem_req", 32'(mem_req), 0);
        chk("abort_mem_addr", 32'(mem_addr), 0);
        chk("abort_buf_valid", 32'(buf_valid), 0);
        chk("abort_err", 32'(err), 0);
        chk("abort_stall", 32'(mem_stall), 0);
        chk_buffer("abort");
        manual = 1'b0;
        run_req(1, 0, 4'd3, 0, 1, 16'h0F0F, 0, 16'd27);

        // address wrap on the high-base instance
        @(negedge clk);
        wbase = wobs_n;
        w_fetch_row = 1'b1; w_row_idx = 3'd0;
        @(negedge clk);
        w_fetch_row = 1'b0;
        cyc = 1; seen = 0;
        while (!seen && cyc < 400) begin
            if (w_bvalid === 1'b1) seen = 1;
            else begin @(negedge clk); cyc++; end
        end
        chk("wrap_buf_valid_seen", 32'(seen), 1);
        chk("wrap_no_err", 32'(w_err), 0);
        chk("wrap_read_count", 32'(wobs_n - wbase), 32'(K));
        for (int i = 0; i < K; i++) begin
            chk($sformatf("wrap_addr[%0d]", i), 32'(wobs[wbase+i]), 32'(ref_addr(1, 0, i, WRAP_BASE)));
            chk($sformatf("wrap_buf[%0d]", i), 32'(w_buffer[i*DW +: DW]), 32'(ref_addr(1, 0, i, WRAP_BASE)));
        end
        @(negedge clk);
        chk("wrap_stall_release", 32'(w_stall), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
